voda_user_rate_monitor: RTL and testbench

//   Downstream consumer of the user detector's one-cycle detection pulse (y).

---
 rtl/voda_user_rate_monitor_pkg.sv | 19 +
 rtl/voda_rpt_fifo.sv | 74 +++++++
 rtl/voda_user_rate_monitor.sv | 141 ++++++++++++++
 tb/tb_voda_user_rate_monitor.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/voda_user_rate_monitor_pkg.sv
// rtl/voda_user_rate_monitor_pkg.sv - shared types for the user rate monitor
//
// Purpose: alarm FSM state encoding shared by the rate monitor top level.
// Report records are packed {index, count, over}, index in the MSBs and
// the over flag in bit 0.
package voda_user_rate_monitor_pkg;

    typedef enum logic [1:0] {
        ST_NORMAL = 2'd0,
        ST_WARN   = 2'd1,
        ST_ALARM  = 2'd2,
        ST_COOL   = 2'd3
    } alarm_state_e;

    function automatic logic alarm_active(input alarm_state_e st);
        return (st == ST_ALARM) || (st == ST_COOL);
    endfunction

endpackage

// File: rtl/voda_rpt_fifo.sv
// rtl/voda_rpt_fifo.sv - first-word-fall-through report record queue
//
// Purpose: synchronous FIFO holding window report records.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   push, push_data write request and record; ignored when full unless popping
//   pop             read request; ignored when empty
//   pop_data        head record (valid whenever !empty)
//   full, empty     occupancy flags
module voda_rpt_fifo #(
    parameter int WIDTH = 19,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full     = (cnt_q == (AW+1)'(DEPTH));
    assign empty    = (cnt_q == '0);
    assign pop_data = mem_q[rd_ptr_q];
    assign do_pop   = pop & ~empty;
    // A full queue still accepts a push when the head leaves the same cycle.
    assign do_push  = push & (~full | do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/voda_user_rate_monitor.sv
// rtl/voda_user_rate_monitor.sv - per-window detection counter with report queue and alarm
//
// Purpose: counts det_pulse per WINDOW_CYCLES window, queues {index,count,over}
// records and raises a hysteretic congestion alarm.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   enable                timer runs and pulses count while high
//   det_pulse             one-cycle detection pulse
//   rpt_valid/rpt_ready   report handshake
//   rpt_index/count/over  head record fields
//   rpt_lost              sticky record-dropped flag
//   alarm                 high in ALARM and COOL states
module voda_user_rate_monitor
    import voda_user_rate_monitor_pkg::*;
#(
    parameter int WINDOW_CYCLES = 1000,
    parameter int CNT_W         = 10,
    parameter int IDX_W         = 8,
    parameter int THRESH        = 8,
    parameter int ALARM_N       = 3,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             det_pulse,
    output logic             rpt_valid,
    input  logic             rpt_ready,
    output logic [IDX_W-1:0] rpt_index,
    output logic [CNT_W-1:0] rpt_count,
    output logic             rpt_over,
    output logic             rpt_lost,
    output logic             alarm
);
    localparam int TMR_W    = $clog2(WINDOW_CYCLES);
    localparam int STREAK_W = $clog2(ALARM_N + 1);
    localparam int REC_W    = IDX_W + CNT_W + 1;

    logic [TMR_W-1:0]    timer_q, timer_d;
    logic [CNT_W-1:0]    acc_q, acc_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    alarm_state_e        state_q, state_d;
    logic                lost_q, lost_d;
    logic                alarm_q, alarm_d;

    logic             win_end, cnt_pulse, close_over, pop, fifo_full, fifo_empty;
    logic [CNT_W:0]   acc_inc;
    logic [CNT_W-1:0] close_cnt;
    logic [REC_W-1:0] head;

    assign cnt_pulse  = enable & det_pulse;
    assign win_end    = enable & (timer_q == TMR_W'(WINDOW_CYCLES - 1));
    // A pulse in the closing cycle belongs to the closing window.
    assign acc_inc    = {1'b0, acc_q} + (CNT_W+1)'(cnt_pulse);
    assign close_cnt  = acc_inc[CNT_W] ? {CNT_W{1'b1}} : acc_inc[CNT_W-1:0];
    assign close_over = (close_cnt >= CNT_W'(THRESH));
    assign pop        = rpt_valid & rpt_ready;

    always_comb begin
        timer_d  = timer_q;
        acc_d    = acc_q;
        idx_d    = idx_q;
        streak_d = streak_q;
        state_d  = state_q;
        lost_d   = lost_q | (win_end & fifo_full & ~pop);
        if (enable) begin
            timer_d = win_end ? '0 : timer_q + TMR_W'(1);
            acc_d   = win_end ? '0 : close_cnt;
        end
        if (win_end) begin
            idx_d = idx_q + IDX_W'(1);
            case (state_q)
                ST_NORMAL: if (close_over) begin
                    streak_d = STREAK_W'(1);
                    state_d  = (ALARM_N == 1) ? ST_ALARM : ST_WARN;
                end
                ST_WARN: if (close_over) begin
                    streak_d = streak_q + STREAK_W'(1);
                    if (streak_q + STREAK_W'(1) == STREAK_W'(ALARM_N)) state_d = ST_ALARM;
                end else begin
                    streak_d = '0;
                    state_d  = ST_NORMAL;
                end
                ST_ALARM: if (!close_over) state_d = ST_COOL;
                ST_COOL: begin
                    if (close_over) begin
                        state_d = ST_ALARM;
                    end else begin
                        state_d  = ST_NORMAL;
                        streak_d = '0;
                    end
                end
                default: state_d = ST_NORMAL;
            endcase
        end
        alarm_d = alarm_active(state_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_q  <= '0;
            acc_q    <= '0;
            idx_q    <= '0;
            streak_q <= '0;
            state_q  <= ST_NORMAL;
            lost_q   <= 1'b0;
            alarm_q  <= 1'b0;
        end else begin
            timer_q  <= timer_d;
            acc_q    <= acc_d;
            idx_q    <= idx_d;
            streak_q <= streak_d;
            state_q  <= state_d;
            lost_q   <= lost_d;
            alarm_q  <= alarm_d;
        end
    end

    voda_rpt_fifo #(
        .WIDTH (REC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (win_end),
        .push_data ({idx_q, close_cnt, close_over}),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign rpt_valid = ~fifo_empty;
    assign rpt_index = head[REC_W-1 -: IDX_W];
    assign rpt_count = head[CNT_W:1];
    assign rpt_over  = head[0];
    assign rpt_lost  = lost_q;
    assign alarm     = alarm_q;

endmodule

// File: tb/tb_voda_user_rate_monitor.sv
// tb/tb_voda_user_rate_monitor.sv - scoreboard bench for voda_user_rate_monitor
module tb_voda_user_rate_monitor;
    localparam int WIN   = 10;
    localparam int CNT_W = 10;
    localparam int IDX_W = 8;
    localparam int THR   = 3;
    localparam int AN    = 2;
    localparam int DEPTH = 2;

    typedef struct {
        int idx;
        int cnt;
        int over;
    } rec_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             enable = 1'b0;
    logic             det_pulse = 1'b0;
    logic             rpt_ready = 1'b1;
    logic             rpt_valid;
    logic [IDX_W-1:0] rpt_index;
    logic [CNT_W-1:0] rpt_count;
    logic             rpt_over;
    logic             rpt_lost;
    logic             alarm;

    int n_checks = 0;
    int n_fail   = 0;

    rec_t exp_q[$];
    int m_tmr, m_acc, m_idx, m_state, m_streak, m_alarm, m_lost;
    int seen_idx[$];

    always #5 clk = ~clk;

    voda_user_rate_monitor #(
        .WINDOW_CYCLES (WIN),
        .CNT_W         (CNT_W),
        .IDX_W         (IDX_W),
        .THRESH        (THR),
        .ALARM_N       (AN),
        .FIFO_DEPTH    (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .det_pulse (det_pulse),
        .rpt_valid (rpt_valid),
        .rpt_ready (rpt_ready),
        .rpt_index (rpt_index),
        .rpt_count (rpt_count),
        .rpt_over  (rpt_over),
        .rpt_lost  (rpt_lost),
        .alarm     (alarm)
    );

    task automatic chk(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_tmr = 0; m_acc = 0; m_idx = 0; m_state = 0; m_streak = 0;
        m_alarm = 0; m_lost = 0;
        exp_q.delete();
    endtask

    // Called at a negedge: compare outputs, drive inputs, advance model, wait a cycle.
    task automatic step(input bit en, input bit p, input bit rdy);
        int   cnt;
        bit   pop, we, over, was_full;
        rec_t r;
        if (exp_q.size() > 0) begin
            chk("rpt_valid", int'(rpt_valid), 1);
            chk("rpt_index", int'(rpt_index), exp_q[0].idx);
            chk("rpt_count", int'(rpt_count), exp_q[0].cnt);
            chk("rpt_over", int'(rpt_over), exp_q[0].over);
        end else begin
            chk("rpt_valid_idle", int'(rpt_valid), 0);
        end
        chk("alarm", int'(alarm), m_alarm);
        chk("rpt_lost", int'(rpt_lost), m_lost);

        enable = en; det_pulse = p; rpt_ready = rdy;

        pop      = rdy && (exp_q.size() > 0);
        we       = en && (m_tmr == WIN - 1);
        was_full = (exp_q.size() == DEPTH);
        cnt      = m_acc + ((en && p) ? 1 : 0);
        if (cnt > (1 << CNT_W) - 1) cnt = (1 << CNT_W) - 1;
        over     = (cnt >= THR);
        if (pop) begin
            seen_idx.push_back(exp_q[0].idx);
            void'(exp_q.pop_front());
        end
        if (we) begin
            r.idx = m_idx; r.cnt = cnt; r.over = over;
            if (was_full && !pop) m_lost = 1;
            else exp_q.push_back(r);
            m_idx = (m_idx + 1) % (1 << IDX_W);
            case (m_state)
                0: if (over) begin m_streak = 1; m_state = (AN == 1) ? 2 : 1; end
                1: if (over) begin
                       m_streak++;
                       if (m_streak == AN) m_state = 2;
                   end else begin m_streak = 0; m_state = 0; end
                2: if (!over) m_state = 3;
                default: if (over) m_state = 2; else begin m_state = 0; m_streak = 0; end
            endcase
            m_alarm = (m_state >= 2) ? 1 : 0;
        end
        if (en) begin
            m_acc = we ? 0 : cnt;
            m_tmr = we ? 0 : m_tmr + 1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // One full window: pulses on cycles 1..np, plus one on the closing cycle if lastp.
    task automatic window(input int np, input bit lastp, input bit rdy);
        for (int c = 0; c < WIN; c++) begin
            step(1'b1, ((c >= 1 && c <= np) || (c == WIN - 1 && lastp)), rdy);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_valid", int'(rpt_valid), 0);
        chk("rst_index", int'(rpt_index), 0);
        chk("rst_count", int'(rpt_count), 0);
        chk("rst_over", int'(rpt_over), 0);
        chk("rst_lost", int'(rpt_lost), 0);
        chk("rst_alarm", int'(alarm), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        do_reset();

        // 1: two pulses then an empty window
        window(2, 0, 1);
        window(0, 0, 1);
        step(1'b0, 1'b0, 1'b1);

        // 2: pulse on the closing cycle counts, next window starts at 0
        do_reset();
        window(3, 1, 1);
        window(1, 0, 1);
        step(1'b0, 1'b0, 1'b1);

        // 3: over, over, clean, clean walks WARN, ALARM, COOL, NORMAL
        do_reset();
        window(3, 0, 1);
        window(5, 0, 1);
        chk("alarm_raised", int'(alarm), 1);
        window(0, 0, 1);
        chk("alarm_cool", int'(alarm), 1);
        window(1, 0, 1);
        chk("alarm_cleared", int'(alarm), 0);
        step(1'b0, 1'b0, 1'b1);

        // 4: consumer stalled for three windows, third record dropped
        do_reset();
        seen_idx.delete();
        window(1, 0, 0);
        window(2, 0, 0);
        window(3, 0, 0);
        chk("lost_set", int'(rpt_lost), 1);
        window(0, 0, 1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        chk("seen_n", seen_idx.size(), 3);
        if (seen_idx.size() == 3) begin
            chk("seen0", seen_idx[0], 0);
            chk("seen1", seen_idx[1], 1);
            chk("seen2", seen_idx[2], 3);
        end

        // 5: enable low for 20 cycles mid-window freezes timer and count
        do_reset();
        for (int c = 0; c < 4; c++) step(1'b1, (c == 1 || c == 2), 1'b1);
        for (int c = 0; c < 20; c++) step(1'b0, 1'b1, 1'b1);
        chk("frozen_valid", int'(rpt_valid), 0);
        for (int c = 0; c < 6; c++) step(1'b1, 1'b0, 1'b1);
        chk("frozen_count", int'(rpt_count), 2);
        step(1'b0, 1'b0, 1'b1);

        // 6: reset mid-window discards partial count, index restarts at 0
        do_reset();
        window(0, 0, 1);
        for (int c = 0; c < 5; c++) step(1'b1, (c == 1 || c == 3), 1'b1);
        do_reset();
        window(1, 0, 1);
        chk("post_rst_index", int'(rpt_index), 0);
        chk("post_rst_count", int'(rpt_count), 1);
        step(1'b0, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
